hack_cpu_ctrl: RTL and testbench
================================

Name: hack_cpu_ctrl

Overview:
Multi-cycle Hack CPU control core. It drives the control and operand side of the hack_alu interface (x, y, zx, nx, zy, ny, f, no) and consumes the ALU result flags (out, zr, ng). It owns the A, D, PC and instruction registers, fetches from an instruction-memory port, accesses data memory through a req/ack port, and sequences each instruction through a small FSM. The hack_alu instance sits outside this block and is wired to the alu_* ports.

Parameters:
none. The Hack ISA fixes all widths: 16-bit data, 15-bit addresses.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
pc  out  15  instruction address, equal to the PC register
instr_req  out  1  instruction fetch request
instr_ack  in  1  instruction valid this cycle
instr  in  16  instruction word, sampled when instr_req & instr_ack
data_addr  out  15  data address, equal to A[14:0]
data_rd  out  1  data read request
data_wr  out  1  data write request
data_wdata  out  16  write data, equal to the RES register
data_ack  in  1  completes data_rd or data_wr this cycle
data_rdata  in  16  read data, sampled when data_rd & data_ack
alu_x  out  16  ALU x operand, equal to D
alu_y  out  16  ALU y operand: IR[12] ? MREG : A
alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  equal to IR[11..6] respectively
alu_out  in  16  ALU result
alu_zr  in  1  ALU result is zero
alu_ng  in  1  ALU result is negative

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous, active-low.
- Registers: A, D, RES, MREG, IR (16b); PC (15b).
- Reset clears every register to 0 and sets state to BOOT. All outputs read 0 during reset, including instr_req, data_rd and data_wr.
- alu_* outputs and data_addr are combinational from registers. instr_req, data_rd and data_wr are decoded from state.
- FSM states: BOOT, FETCH, DECODE, MREAD, EXEC, MWRITE.
- BOOT: lasts one cycle, then goes to FETCH.
- FETCH: instr_req=1. On instr_ack, IR<=instr and go to DECODE. Otherwise hold, with no timeout.
- DECODE, A-instruction (IR[15]=0): A<={1'b0,IR[14:0]}, PC<=PC+1, go to FETCH.
- DECODE, C-instruction: go to MREAD if IR[12]=1, else EXEC. IR[14:13] are ignored.
- MREAD: data_rd=1 at address A. On data_ack, MREG<=data_rdata and go to EXEC.
- EXEC (ALU sampled this cycle):
  - RES<=alu_out.
  - If IR[5], A<=alu_out.
  - If IR[4], D<=alu_out.
  - jump = (IR[2]&ng) | (IR[1]&zr) | (IR[0]&~zr&~ng).
  - PC <= jump ? A_old[14:0] : PC+1.
  - Go to MWRITE if IR[3], else FETCH.
- MWRITE: data_wr=1, data_wdata=RES, data_addr=A_old. On data_ack, go to FETCH.
- A_old means A before this instruction's EXEC write. Implement it by latching the write address and jump target in a 15-bit WADDR register at DECODE. data_addr outputs WADDR while in MWRITE.
- PC wraps 0x7FFF -> 0x0000 with no flag.
- Minimum cycle counts (acks arrive immediately):
  - A-instruction: 2 cycles.
  - C-instruction: 3 cycles, plus 1 if IR[12]=1, plus 1 if IR[3]=1.
- Stall: each wait state holds every register and output stable until its ack arrives.
- Acks outside their state are ignored: instr_ack outside FETCH, data_ack outside MREAD/MWRITE.
- data_rd and data_wr are never asserted together.
- Reset mid-operation: outputs drop asynchronously, so a pending data_wr is abandoned. Execution restarts at PC=0 via BOOT.

Test Plan:
1. Release reset, ack first fetch with 0x0002 -> instr_req low for exactly the BOOT cycle, then A=0x0002, pc=1, alu_x=0; 2 cycles from fetch ack to next instr_req.
2. Then 0xEC10 (D=A) -> in EXEC alu_zx..no=110000, alu_y=0x0002; afterwards D=0x0002, pc=2, no data_rd/wr.
3. 0x0005, then 0xE308 (M=D) with data_ack delayed 3 cycles -> data_wr held 3 cycles, data_addr=5, data_wdata=0x0002; state, pc=4 and all outputs stable across the stall.
4. 0xFC10 (D=M), data_rdata=0x7FFF -> data_rd at addr 5, alu_y=0x7FFF in EXEC, D=0x7FFF.
5. 0x000A, then 0xE301 (D;JGT) with D=0x7FFF -> pc=0x000A. Repeat with D=0 -> pc=PC+1. Then 0xEA87 (0;JMP) -> pc=A. Also PC=0x7FFF with an A-instruction -> pc=0x0000.
6. Assert rst_n=0 mid-MWRITE -> data_wr=0 immediately; A, D and pc = 0; after release one BOOT cycle, then fetch at pc=0.

Source files
------------

// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl: multi-cycle Hack CPU sequencer owning A/D/PC/IR and driving an external hack_alu
module hack_cpu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  output logic [14:0] pc,
  output logic        instr_req,
  input  logic        instr_ack,
  input  logic [15:0] instr,
  output logic [14:0] data_addr,
  output logic        data_rd,
  output logic        data_wr,
  output logic [15:0] data_wdata,
  input  logic        data_ack,
  input  logic [15:0] data_rdata,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng
);
  typedef enum logic [2:0] {BOOT, FETCH, DECODE, MREAD, EXEC, MWRITE} state_t;
  state_t state, state_nx;
  logic [15:0] a, d, res, mreg, ir;
  logic [14:0] waddr;
  logic jump;
  always_comb begin
    state_nx = state;
    case (state)
      BOOT:    state_nx = FETCH;
      FETCH:   state_nx = instr_ack ? DECODE : FETCH;
      DECODE:  state_nx = !ir[15] ? FETCH : ir[12] ? MREAD : EXEC;
      MREAD:   state_nx = data_ack ? EXEC : MREAD;
      EXEC:    state_nx = ir[3] ? MWRITE : FETCH;
      MWRITE:  state_nx = data_ack ? FETCH : MWRITE;
      default: state_nx = BOOT;
    endcase
  end
  assign jump = (ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_zr & ~alu_ng);
  // waddr freezes A at DECODE so EXEC can overwrite A while the store/jump still use the old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      a     <= '0;
      d     <= '0;
      res   <= '0;
      mreg  <= '0;
      ir    <= '0;
      pc    <= '0;
      waddr <= '0;
    end else begin
      state <= state_nx;
      if (state == FETCH && instr_ack) ir <= instr;
      if (state == DECODE) begin
        waddr <= a[14:0];
        if (!ir[15]) begin
          a  <= {1'b0, ir[14:0]};
          pc <= pc + 15'd1;
        end
      end
      if (state == MREAD && data_ack) mreg <= data_rdata;
      if (state == EXEC) begin
        res <= alu_out;
        if (ir[5]) a <= alu_out;
        if (ir[4]) d <= alu_out;
        pc <= jump ? waddr : pc + 15'd1;
      end
    end
  end
  assign instr_req  = state == FETCH;
  assign data_rd    = state == MREAD;
  assign data_wr    = state == MWRITE;
  assign data_addr  = data_wr ? waddr : a[14:0];
  assign data_wdata = res;
  assign alu_x      = d;
  assign alu_y      = ir[12] ? mreg : a;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir[11:6];
endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// tb_hack_cpu_ctrl: random-stall memory responders, ISA-level reference model and a transaction scoreboard
module tb_hack_cpu_ctrl;
  logic clk = 0, rst_n = 1;
  logic [14:0] pc, data_addr;
  logic instr_req, instr_ack, data_rd, data_wr, data_ack;
  logic [15:0] instr, data_wdata, data_rdata, alu_x, alu_y, alu_out;
  logic alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
  always #5 clk = ~clk;

  hack_cpu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instr_req(instr_req), .instr_ack(instr_ack), .instr(instr),
    .data_addr(data_addr), .data_rd(data_rd), .data_wr(data_wr), .data_wdata(data_wdata),
    .data_ack(data_ack), .data_rdata(data_rdata), .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
  );

  function automatic logic [15:0] alu(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0 : y;
    yy = c[2] ? ~yy : yy;
    o  = c[1] ? xx + yy : xx & yy;
    return c[0] ? ~o : o;
  endfunction

  // external hack_alu stand-in
  assign alu_out = alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
  assign alu_zr  = alu_out == 16'h0;
  assign alu_ng  = alu_out[15];

  localparam int KF = 0, KR = 1, KW = 2;
  typedef struct {int kind; logic [14:0] addr; logic [15:0] data; int gap;} txn_t;
  txn_t q[$];
  logic [15:0] imem [0:32767];
  logic [15:0] dmem_d [0:32767];
  logic [15:0] dmem_m [0:32767];
  logic [15:0] ma, md;
  logic [14:0] mpc;
  int mgap;
  int n = 0, fails = 0;
  bit stop = 0, hold = 0;
  logic [86:0] snap;
  assign snap = {pc, instr_req, data_addr, data_rd, data_wr, data_wdata, alu_x, alu_y,
                 alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    n++;
    fails++;
    $display("FAIL %s at time %0t", nm, $time);
  endtask

  task automatic push(input int k, input logic [14:0] a, input logic [15:0] dt, input int g);
    txn_t t;
    t.kind = k; t.addr = a; t.data = dt; t.gap = g;
    q.push_back(t);
  endtask

  // ISA-level model: one call per instruction, emits the bus transactions it must cause
  task automatic model_fetch();
    push(KF, mpc, 16'h0, mgap);
  endtask

  task automatic model_body();
    logic [15:0] i, y, r;
    logic [14:0] ao;
    logic j;
    i = imem[mpc];
    if (!i[15]) begin
      ma = {1'b0, i[14:0]};
      mpc = mpc + 15'd1;
      mgap = 2;
    end else begin
      ao = ma[14:0];
      y = i[12] ? dmem_m[ao] : ma;
      if (i[12]) push(KR, ao, dmem_m[ao], 0);
      r = alu(md, y, i[11:6]);
      if (i[5]) ma = r;
      if (i[4]) md = r;
      if (i[3]) begin
        push(KW, ao, r, 0);
        dmem_m[ao] = r;
      end
      j = (i[2] && r[15]) || (i[1] && r == 16'h0) || (i[0] && r != 16'h0 && !r[15]);
      mpc = j ? ao : mpc + 15'd1;
      mgap = 3 + int'(i[12]) + int'(i[3]);
    end
  endtask

  // instruction memory with random wait states and spurious acks when idle
  initial begin
    int ic = 0, idly = 0;
    instr_ack = 0;
    instr = 0;
    forever begin
      @(posedge clk);
      #1;
      if (instr_req && !stop) begin
        instr = imem[pc];
        instr_ack = ic >= idly;
        ic++;
        if (instr_ack) begin
          ic = 0;
          idly = $urandom_range(0, 3);
        end
      end else begin
        ic = 0;
        instr_ack = !stop && !instr_req && $urandom_range(0, 3) == 0;
        instr = 16'($urandom);
      end
    end
  end

  initial begin
    int dc = 0, ddly = 0;
    data_ack = 0;
    data_rdata = 0;
    forever begin
      @(posedge clk);
      #1;
      if ((data_rd || data_wr) && !stop && !(hold && data_wr && data_addr == 15'd3)) begin
        data_rdata = dmem_d[data_addr];
        data_ack = dc >= ddly;
        dc++;
        if (data_ack) begin
          dc = 0;
          ddly = $urandom_range(0, 3);
        end
      end else begin
        dc = 0;
        data_ack = !stop && !(data_rd || data_wr) && $urandom_range(0, 3) == 0;
        data_rdata = 16'($urandom);
      end
    end
  end

  // monitor: pops the scoreboard on every handshake, checks cycle counts and stall stability
  initial begin
    int since = 0, stalls = 0;
    bit pv = 0, ppend = 0, pend;
    logic [86:0] psnap = '0;
    txn_t t;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0;
        since = 0;
        stalls = 0;
      end else begin
        since++;
        if (pv && ppend) chk("stall_stable", snap, psnap);
        pend = (instr_req && !instr_ack) || (data_rd && !data_ack) || (data_wr && !data_ack);
        if (pend) stalls++;
        if (instr_req && instr_ack) begin
          if (q.size() == 0) miss("fetch_unexpected");
          else begin
            t = q.pop_front();
            chk("fetch_kind", t.kind, KF);
            chk("fetch_pc", pc, t.addr);
            if (t.gap >= 0) chk("fetch_cycles", since, t.gap + stalls);
          end
          since = 0;
          stalls = 0;
        end
        if (data_rd && data_ack) begin
          chk("rd_excl", data_wr, 0);
          if (q.size() == 0) miss("read_unexpected");
          else begin
            t = q.pop_front();
            chk("read_kind", t.kind, KR);
            chk("read_addr", data_addr, t.addr);
          end
        end
        if (data_wr && data_ack) begin
          chk("wr_excl", data_rd, 0);
          if (q.size() == 0) miss("write_unexpected");
          else begin
            t = q.pop_front();
            chk("write_kind", t.kind, KW);
            chk("write_addr", data_addr, t.addr);
            chk("write_data", data_wdata, t.data);
          end
          dmem_d[data_addr] = data_wdata;
        end
        pv = 1;
        ppend = pend;
        psnap = snap;
      end
    end
  end

  initial begin
    int k;
    for (int i = 0; i < 32768; i++) begin
      imem[i] = 16'($urandom);
      dmem_d[i] = 16'($urandom);
      dmem_m[i] = dmem_d[i];
    end
    imem[0] = 16'h0002; imem[1] = 16'hEC10; imem[2] = 16'h0005; imem[3] = 16'hE308;
    imem[4] = 16'hFC10; imem[5] = 16'h000A; imem[6] = 16'hE301;
    imem[10] = 16'hEA90; imem[11] = 16'h000A; imem[12] = 16'hE301;
    imem[13] = 16'h0010; imem[14] = 16'hEA87; imem[16] = 16'h0003; imem[17] = 16'hE308;
    ma = 0; md = 0; mpc = 0; mgap = -1;
    for (int i = 0; i < 13; i++) begin
      model_fetch();
      model_body();
    end
    model_fetch();
    hold = 1;
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", snap, 0);
    #2 rst_n = 1;
    chk("boot_req", instr_req, 0);
    @(posedge clk);
    #2;
    chk("first_fetch_req", instr_req, 1);
    chk("first_fetch_pc", pc, 0);
    for (k = 0; k < 3000 && !(data_wr && data_addr == 15'd3); k++) @(negedge clk);
    if (k == 3000) miss("held_write_timeout");
    repeat (2) @(negedge clk);
    chk("phase1_drained", q.size(), 0);
    chk("held_wr", data_wr, 1);
    chk("held_wdata", data_wdata, md);
    #2 rst_n = 0;
    #1;
    chk("rst_wr_drop", data_wr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_d", alu_x, 0);
    chk("rst_a", data_addr, 0);
    chk("rst_all", snap, 0);
    hold = 0;
    imem[0] = 16'h0020; imem[1] = 16'hE302;
    imem[32] = 16'hEFD0; imem[33] = 16'h7FFF; imem[34] = 16'hEA87; imem[32767] = 16'h0007;
    ma = 0; md = 0; mpc = 0; mgap = -1;
    for (int i = 0; i < 400; i++) begin
      model_fetch();
      model_body();
    end
    model_fetch();
    @(negedge clk);
    #2 rst_n = 1;
    chk("reboot_req", instr_req, 0);
    @(posedge clk);
    #2;
    chk("refetch_req", instr_req, 1);
    chk("refetch_pc", pc, 0);
    for (k = 0; k < 40000 && q.size() != 0; k++) @(posedge clk);
    stop = 1;
    if (q.size() != 0) miss("drain_timeout");
    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
